// File: rtl/moore_4_detector_pkg.sv
// moore_4_detector_pkg: state encoding, target pattern and next-state function for the 1011 detector
package moore_4_detector_pkg;

    localparam int STATE_W = 3;
    localparam logic [3:0] PATTERN = 4'b1011;

    typedef enum logic [STATE_W-1:0] {S0, S1, S2, S3, S4} state_t;

    // Encodings 5..7 fall into default and recover to S0
    function automatic state_t next_state(state_t s, logic b, logic overlap);
        case (s)
            S0:      return (b == PATTERN[3]) ? S1 : S0;
            S1:      return (b == PATTERN[2]) ? S2 : S1;
            S2:      return (b == PATTERN[1]) ? S3 : S0;
            S3:      return (b == PATTERN[0]) ? S4 : S2;
            S4:      return b ? S1 : (overlap ? S2 : S0);
            default: return S0;
        endcase
    endfunction

endpackage

// File: rtl/moore_4_detector_if.sv
// moore_4_detector_if: serial bit in, registered detect flag out
interface moore_4_detector_if;
    logic sample;
    logic detect;
    modport master (output sample, input detect);
    modport slave (input sample, output detect);
endinterface

// File: rtl/moore_4_detector.sv
// moore_4_detector: Moore FSM flagging each serial occurrence of 1011 with a one-cycle pulse
module moore_4_detector
    import moore_4_detector_pkg::*;
#(
    parameter logic OVERLAP = 1'b1
) (
    input logic clk,
    input logic rst_n,
    moore_4_detector_if.slave bus
);
    state_t state;
    state_t nxt;

    assign nxt = next_state(state, bus.sample, OVERLAP);

    // detect is a flop mirroring state==S4, so it never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S0;
            bus.detect <= 1'b0;
        end else begin
            state <= nxt;
            bus.detect <= (nxt == S4);
        end
    end
endmodule

// File: tb/tb_moore_4_detector.sv
// tb_moore_4_detector: directed checks of the 1011 detector with and without overlap
module tb_moore_4_detector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    moore_4_detector_if bus1 ();
    moore_4_detector_if bus0 ();

    moore_4_detector #(.OVERLAP(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    moore_4_detector #(.OVERLAP(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive n bits MSB-first; e1/e0 hold the expected detect after each edge for OVERLAP=1/0
    task automatic run(input string tag, input logic [31:0] bits, input int n,
                       input logic [31:0] e1, input logic [31:0] e0);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            bus1.sample = bits[i];
            bus0.sample = bits[i];
            @(posedge clk);
            #1;
            chk($sformatf("%s_ov1_e%0d", tag, n - i), bus1.detect, e1[i]);
            chk($sformatf("%s_ov0_e%0d", tag, n - i), bus0.detect, e0[i]);
        end
    endtask

    initial begin
        bus1.sample = 1'b1;
        bus0.sample = 1'b1;
        #1;
        chk("reset_ov1", bus1.detect, 1'b0);
        chk("reset_ov0", bus0.detect, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_held_ov1", bus1.detect, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run("idle", 32'b000, 3, 32'b000, 32'b000);
        run("basic", 32'b101100, 6, 32'b000100, 32'b000100);
        run("overlap", 32'b101101100, 9, 32'b000100100, 32'b000100000);
        run("miss_a", 32'b1101100, 7, 32'b0000100, 32'b0000100);
        run("miss_b", 32'b100101100, 9, 32'b000000100, 32'b000000100);
        run("stream", 32'b0010110010110011100101100, 25,
            32'b0000010000010000000000100, 32'b0000010000010000000000100);

        // Async reset while the pulse is high must clear it between edges
        run("pre_rst", 32'b1011, 4, 32'b0001, 32'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clr_ov1", bus1.detect, 1'b0);
        chk("async_clr_ov0", bus0.detect, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Partial 101 must be discarded by a mid-cycle reset
        run("partial", 32'b101, 3, 32'b000, 32'b000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("partial_rst_ov1", bus1.detect, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 32'b1011, 4, 32'b0001, 32'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
